hwpe_stream_merge_stride: RTL and testbench

//  Gathers NB_IN_STREAMS narrow HWPE-Stream lanes into one wide HWPE-Stream word, interleaving elements.

---
 rtl/hwpe_stream_merge_stride.sv | 74 +++++++
 tb/tb_hwpe_stream_merge_stride.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_merge_stride.sv
// Gathers NB_IN_STREAMS narrow HWPE-Stream lanes into one wide word, interleaving elements
// so that lane ii element jj lands at wide element jj*NB_IN_STREAMS+ii.
module hwpe_stream_merge_stride #(
  parameter int unsigned NB_IN_STREAMS  = 4,
  parameter int unsigned DATA_WIDTH_OUT = 256,
  parameter int unsigned ELEMENT_WIDTH  = 16,
  localparam int unsigned DATA_WIDTH_IN  = DATA_WIDTH_OUT / NB_IN_STREAMS,
  localparam int unsigned ELEMS_PER_LANE = DATA_WIDTH_IN / ELEMENT_WIDTH,
  localparam int unsigned EB             = ELEMENT_WIDTH / 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          clear_i,
  input  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN-1:0]   push_data_i,
  input  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN/8-1:0] push_strb_i,
  input  logic [NB_IN_STREAMS-1:0]                      push_valid_i,
  output logic [NB_IN_STREAMS-1:0]                      push_ready_o,
  output logic [DATA_WIDTH_OUT-1:0]                     pop_data_o,
  output logic [DATA_WIDTH_OUT/8-1:0]                   pop_strb_o,
  output logic                                          pop_valid_o,
  input  logic                                          pop_ready_i
);

  logic [NB_IN_STREAMS-1:0]                      held_q;
  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN-1:0]   data_h;
  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN/8-1:0] strb_h;

  logic [NB_IN_STREAMS-1:0]                      avail;
  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN-1:0]   lane_data;
  logic [NB_IN_STREAMS-1:0][DATA_WIDTH_IN/8-1:0] lane_strb;
  logic                                          fire;

  always_comb begin
    avail     = held_q | push_valid_i;
    lane_data = push_data_i;
    lane_strb = push_strb_i;
    for (int ii = 0; ii < int'(NB_IN_STREAMS); ii++) begin
      if (held_q[ii]) begin
        lane_data[ii] = data_h[ii];
        lane_strb[ii] = strb_h[ii];
      end
    end
    // Lane ready depends only on local hold state: no ready->ready path.
    pop_valid_o  = (&avail) & ~rst_i;
    push_ready_o = ~held_q & {NB_IN_STREAMS{~rst_i}};
    fire         = pop_valid_o & pop_ready_i;
  end

  for (genvar ii = 0; ii < NB_IN_STREAMS; ii++) begin : gen_lane
    for (genvar jj = 0; jj < ELEMS_PER_LANE; jj++) begin : gen_elem
      assign pop_data_o[(jj*NB_IN_STREAMS+ii)*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
          lane_data[ii][jj*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      assign pop_strb_o[(jj*NB_IN_STREAMS+ii)*EB +: EB] = lane_strb[ii][jj*EB +: EB];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        held_q[ii] <= 1'b0;
        data_h[ii] <= '0;
        strb_h[ii] <= '0;
      end else if (clear_i) begin
        // Drop any partially gathered word; payload registers are left as-is.
        held_q[ii] <= 1'b0;
      end else if (fire) begin
        held_q[ii] <= 1'b0;
      end else if (push_valid_i[ii] && !held_q[ii]) begin
        held_q[ii] <= 1'b1;
        data_h[ii] <= push_data_i[ii];
        strb_h[ii] <= push_strb_i[ii];
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_merge_stride.sv
// Scoreboard bench for hwpe_stream_merge_stride: expected wide words are queued when the last
// lane is driven and compared whenever a fire is seen on the merged stream.
module tb_hwpe_stream_merge_stride;

  localparam int NB  = 4;
  localparam int DWO = 256;
  localparam int EW  = 16;
  localparam int DWI = DWO / NB;
  localparam int EB  = EW / 8;
  localparam int NE  = DWO / EW;

  typedef struct packed {
    logic [DWO-1:0]   data;
    logic [DWO/8-1:0] strb;
  } word_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        clear;
  logic [NB-1:0][DWI-1:0]      push_data;
  logic [NB-1:0][DWI/8-1:0]    push_strb;
  logic [NB-1:0]               push_valid;
  logic [NB-1:0]               push_ready;
  logic [DWO-1:0]              pop_data;
  logic [DWO/8-1:0]            pop_strb;
  logic                        pop_valid;
  logic                        pop_ready;

  int    checks = 0;
  int    passed = 0;
  word_t exp_q[$];

  hwpe_stream_merge_stride #(
    .NB_IN_STREAMS (NB),
    .DATA_WIDTH_OUT(DWO),
    .ELEMENT_WIDTH (EW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .push_data_i (push_data),
    .push_strb_i (push_strb),
    .push_valid_i(push_valid),
    .push_ready_o(push_ready),
    .pop_data_o  (pop_data),
    .pop_strb_o  (pop_strb),
    .pop_valid_o (pop_valid),
    .pop_ready_i (pop_ready)
  );

  always #5 clk = ~clk;

  // Lane ii element jj = {tag, 4'h0, ii, jj}.
  function automatic logic [DWI-1:0] lane_word(logic [3:0] tag, int ii);
    logic [DWI-1:0] w;
    for (int jj = 0; jj < DWI / EW; jj++) w[jj*EW +: EW] = {tag, 4'h0, 4'(ii), 4'(jj)};
    return w;
  endfunction

  // Wide element k comes from lane k%NB, element k/NB.
  function automatic word_t exp_word(logic [3:0] tag, logic [NE-1:0] elem_on);
    word_t w;
    for (int k = 0; k < NE; k++) begin
      w.data[k*EW +: EW] = {tag, 4'h0, 4'(k % NB), 4'(k / NB)};
      w.strb[k*EB +: EB] = elem_on[k] ? 2'b11 : 2'b00;
    end
    return w;
  endfunction

  task automatic drive(logic [3:0] tag, logic [NB-1:0] valid);
    for (int ii = 0; ii < NB; ii++) begin
      push_data[ii] = lane_word(tag, ii);
      push_strb[ii] = '1;
    end
    push_valid = valid;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && !clear && pop_valid && pop_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_fire: got data %h, expected no fire", pop_data);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (pop_data !== e.data || pop_strb !== e.strb)
          $display("FAIL fire_word: got %h/%h, expected %h/%h", pop_data, pop_strb, e.data,
                   e.strb);
        else passed++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; pop_ready = 1'b1;
    drive(4'h9, '1);
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b0 || push_ready !== '0)
      $display("FAIL reset_outputs: got valid %b ready %b, expected 0 0000", pop_valid, push_ready);
    else passed++;
    next_cycle();
    rst = 1'b0;
    push_valid = '0;
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b0 || push_ready !== '1)
      $display("FAIL after_reset: got valid %b ready %b, expected 0 1111", pop_valid, push_ready);
    else passed++;
  endtask

  task automatic test_all_valid();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(4'(4'hA + c), '1);
      exp_q.push_back(exp_word(4'(4'hA + c), '1));
      @(negedge clk);
      checks++;
      if (pop_valid !== 1'b1 || push_ready !== '1)
        $display("FAIL bypass_hs: got valid %b ready %b, expected 1 1111", pop_valid, push_ready);
      else passed++;
      checks++;
      if (pop_data[0*EW +: EW] !== {4'(4'hA + c), 12'h000} ||
          pop_data[1*EW +: EW] !== {4'(4'hA + c), 12'h010} ||
          pop_data[4*EW +: EW] !== {4'(4'hA + c), 12'h001} ||
          pop_data[15*EW +: EW] !== {4'(4'hA + c), 12'h033})
        $display("FAIL elem_map: got e0 %h e1 %h e4 %h e15 %h, expected tag %h 000/010/001/033",
                 pop_data[0*EW +: EW], pop_data[1*EW +: EW], pop_data[4*EW +: EW],
                 pop_data[15*EW +: EW], 4'(4'hA + c));
      else passed++;
    end
    next_cycle();
    push_valid = '0;
  endtask

  task automatic test_late_lanes();
    next_cycle();
    drive(4'hD, 4'b0100);
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b0 || push_ready[2] !== 1'b1)
      $display("FAIL late_t0: got valid %b ready2 %b, expected 0 1", pop_valid, push_ready[2]);
    else passed++;
    for (int t = 1; t < 3; t++) begin
      next_cycle();
      push_valid = '0;
      @(negedge clk);
      checks++;
      if (pop_valid !== 1'b0 || push_ready !== 4'b1011)
        $display("FAIL late_wait: got valid %b ready %b, expected 0 1011", pop_valid, push_ready);
      else passed++;
    end
    next_cycle();
    drive(4'hD, 4'b1011);
    exp_q.push_back(exp_word(4'hD, '1));
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b1)
      $display("FAIL late_t3: got valid %b, expected 1", pop_valid);
    else passed++;
    next_cycle();
    push_valid = '0;
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b0 || push_ready !== '1)
      $display("FAIL late_t4: got valid %b ready %b, expected 0 1111", pop_valid, push_ready);
    else passed++;
  endtask

  task automatic test_stall();
    word_t e;
    e = exp_word(4'hE, '1);
    next_cycle();
    pop_ready = 1'b0;
    drive(4'hE, '1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== e.data || pop_strb !== e.strb)
        $display("FAIL stall_hold c%0d: got valid %b data %h, expected 1 %h", c, pop_valid,
                 pop_data, e.data);
      else passed++;
      if (c > 0) begin
        checks++;
        if (push_ready !== '0)
          $display("FAIL stall_ready c%0d: got %b, expected 0000", c, push_ready);
        else passed++;
      end
      next_cycle();
      push_valid = '0;
    end
    pop_ready = 1'b1;
    exp_q.push_back(e);
    next_cycle();
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b0 || push_ready !== '1)
      $display("FAIL stall_nodup: got valid %b ready %b, expected 0 1111", pop_valid, push_ready);
    else passed++;
  endtask

  task automatic test_strobe();
    next_cycle();
    drive(4'hF, '1);
    push_strb[1] = 8'h0F;
    // Lane 1 elements 2 and 3 are wide elements 9 and 13.
    exp_q.push_back(exp_word(4'hF, ~((NE'(1) << 9) | (NE'(1) << 13))));
    @(negedge clk);
    checks++;
    if (pop_strb[3:2] !== 2'b11 || pop_strb[11:10] !== 2'b11 ||
        pop_strb[19:18] !== 2'b00 || pop_strb[27:26] !== 2'b00)
      $display("FAIL strb_lane1: got [3:2]=%b [11:10]=%b [19:18]=%b [27:26]=%b, expected 11 11 00 00",
               pop_strb[3:2], pop_strb[11:10], pop_strb[19:18], pop_strb[27:26]);
    else passed++;
    next_cycle();
    push_valid = '0;
  endtask

  task automatic test_mid_reset();
    next_cycle();
    drive(4'h3, 4'b0011);
    next_cycle();
    push_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b0)
      $display("FAIL rst_valid: got %b, expected 0", pop_valid);
    else passed++;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (push_ready !== '1 || pop_valid !== 1'b0)
      $display("FAIL rst_cleared: got ready %b valid %b, expected 1111 0", push_ready, pop_valid);
    else passed++;
    next_cycle();
    drive(4'h5, '1);
    exp_q.push_back(exp_word(4'h5, '1));
    next_cycle();
    push_valid = '0;
  endtask

  task automatic test_clear();
    next_cycle();
    drive(4'h6, 4'b1000);
    next_cycle();
    drive(4'h7, 4'b0111);
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (pop_valid !== 1'b1)
      $display("FAIL clear_ungated: got valid %b, expected 1", pop_valid);
    else passed++;
    next_cycle();
    clear = 1'b0;
    push_valid = '0;
    @(negedge clk);
    checks++;
    if (push_ready !== '1 || pop_valid !== 1'b0)
      $display("FAIL clear_after: got ready %b valid %b, expected 1111 0", push_ready, pop_valid);
    else passed++;
    next_cycle();
    drive(4'h8, '1);
    exp_q.push_back(exp_word(4'h8, '1));
    next_cycle();
    push_valid = '0;
  endtask

  initial begin
    push_valid = '0;
    push_data  = '0;
    push_strb  = '0;
    test_reset();
    test_all_valid();
    test_late_lanes();
    test_stall();
    test_strobe();
    test_mid_reset();
    test_clear();
    next_cycle();
    next_cycle();
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL missing_fires: got %0d words left, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
